// File: rtl/regfile_writeback.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_writeback: arbitrates EXU/LSU results into one RF write per cycle |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module regfile_writeback #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_exu_valid,
  output logic                  o_exu_ready,
  input  logic [ADDR_WIDTH-1:0] i_exu_rd,
  input  logic [DATA_WIDTH-1:0] i_exu_data,
  input  logic                  i_lsu_valid,
  output logic                  o_lsu_ready,
  input  logic [ADDR_WIDTH-1:0] i_lsu_rd,
  input  logic [DATA_WIDTH-1:0] i_lsu_rdata,
  input  logic [2:0]            i_lsu_funct3,
  input  logic [1:0]            i_lsu_addr_lo,
  output logic                  o_rf_wen,
  output logic [ADDR_WIDTH-1:0] o_rf_waddr,
  output logic [DATA_WIDTH-1:0] o_rf_wdata,
  output logic                  o_retire_valid,
  output logic                  o_misalign_err,
  output logic [CNT_WIDTH-1:0]  o_retire_cnt
);

  localparam int c_SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_SW-1:0]      c_STARVE_MAX = c_SW'(STARVE_LIMIT);
  localparam logic [c_SW-1:0]      c_STARVE_ONE = c_SW'(1);
  localparam logic [CNT_WIDTH-1:0] c_CNT_ONE    = CNT_WIDTH'(1);
  localparam logic [2:0] c_F3_LB  = 3'b000;
  localparam logic [2:0] c_F3_LH  = 3'b001;
  localparam logic [2:0] c_F3_LW  = 3'b010;
  localparam logic [2:0] c_F3_LBU = 3'b100;
  localparam logic [2:0] c_F3_LHU = 3'b101;

  logic [c_SW-1:0]       r_starve;
  logic                  r_wen;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_retire;
  logic                  r_misalign;
  logic [CNT_WIDTH-1:0]  r_cnt;

  logic                  w_grant_exu;
  logic                  w_grant_lsu;
  logic                  w_xfer;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_WIDTH-1:0] w_load_data;
  logic                  w_load_bad;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic [ADDR_WIDTH-1:0] w_sel_rd;
  logic                  w_sel_bad;

  // LSU has priority unless EXU is alone or has lost STARVE_LIMIT times in a row.
  assign w_grant_exu = rst_n && i_exu_valid && (!i_lsu_valid || (r_starve == c_STARVE_MAX));
  assign w_grant_lsu = rst_n && i_lsu_valid && !w_grant_exu;
  assign w_xfer      = w_grant_exu || w_grant_lsu;
  assign o_exu_ready = w_grant_exu;
  assign o_lsu_ready = w_grant_lsu;

  always_comb begin
    w_byte      = 8'h00;
    w_half      = i_lsu_addr_lo[1] ? i_lsu_rdata[31:16] : i_lsu_rdata[15:0];
    w_load_data = i_lsu_rdata;
    w_load_bad  = 1'b0;
    case (i_lsu_addr_lo)
      2'd0:    w_byte = i_lsu_rdata[7:0];
      2'd1:    w_byte = i_lsu_rdata[15:8];
      2'd2:    w_byte = i_lsu_rdata[23:16];
      default: w_byte = i_lsu_rdata[31:24];
    endcase
    case (i_lsu_funct3)
      c_F3_LB:  w_load_data = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
      c_F3_LBU: w_load_data = {{(DATA_WIDTH-8){1'b0}}, w_byte};
      c_F3_LH: begin
        w_load_data = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
        w_load_bad  = i_lsu_addr_lo[0];
      end
      c_F3_LHU: begin
        w_load_data = {{(DATA_WIDTH-16){1'b0}}, w_half};
        w_load_bad  = i_lsu_addr_lo[0];
      end
      c_F3_LW:  w_load_bad = (i_lsu_addr_lo != 2'b00);
      default:  w_load_bad = 1'b1;
    endcase
  end

  assign w_sel_data = w_grant_exu ? i_exu_data : w_load_data;
  assign w_sel_rd   = w_grant_exu ? i_exu_rd   : i_lsu_rd;
  assign w_sel_bad  = w_grant_lsu && w_load_bad;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (w_grant_exu) begin
      r_starve <= '0;
    end else if (i_exu_valid && (r_starve != c_STARVE_MAX)) begin
      r_starve <= r_starve + c_STARVE_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wen      <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_retire   <= 1'b0;
      r_misalign <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_wen      <= w_xfer && !w_sel_bad && (w_sel_rd != '0);
      r_retire   <= w_xfer;
      r_misalign <= w_sel_bad;
      if (w_xfer) begin
        r_waddr <= w_sel_rd;
        r_wdata <= w_sel_data;
        r_cnt   <= r_cnt + c_CNT_ONE;
      end
    end
  end

  assign o_rf_wen       = r_wen;
  assign o_rf_waddr     = r_waddr;
  assign o_rf_wdata     = r_wdata;
  assign o_retire_valid = r_retire;
  assign o_misalign_err = r_misalign;
  assign o_retire_cnt   = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_regfile_writeback: directed self-checking bench for regfile_writeback  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_regfile_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exu_valid, lsu_valid;
  logic        exu_ready, lsu_ready;
  logic [4:0]  exu_rd, lsu_rd;
  logic [31:0] exu_data, lsu_rdata;
  logic [2:0]  lsu_funct3;
  logic [1:0]  lsu_addr_lo;
  logic        rf_wen, retire_valid, misalign_err;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] retire_cnt;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_cnt;

  always #5 clk = ~clk;

  regfile_writeback #(
    .ADDR_WIDTH(5), .DATA_WIDTH(32), .STARVE_LIMIT(4), .CNT_WIDTH(32)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_exu_valid(exu_valid), .o_exu_ready(exu_ready),
    .i_exu_rd(exu_rd), .i_exu_data(exu_data),
    .i_lsu_valid(lsu_valid), .o_lsu_ready(lsu_ready),
    .i_lsu_rd(lsu_rd), .i_lsu_rdata(lsu_rdata),
    .i_lsu_funct3(lsu_funct3), .i_lsu_addr_lo(lsu_addr_lo),
    .o_rf_wen(rf_wen), .o_rf_waddr(rf_waddr), .o_rf_wdata(rf_wdata),
    .o_retire_valid(retire_valid), .o_misalign_err(misalign_err),
    .o_retire_cnt(retire_cnt)
  );

  // Advance one clock; return 1ns after the edge with outputs settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; exu_valid = 1'b1; lsu_valid = 1'b1;
    exu_rd = 5'd9; exu_data = 32'h1234_5678;
    lsu_rd = 5'd4; lsu_rdata = 32'hFFFF_FFFF; lsu_funct3 = 3'b010; lsu_addr_lo = 2'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({exu_ready, lsu_ready} !== 2'b00) begin
        n_errors++; $display("FAIL reset_readies cyc%0d: got %b expected 00", i, {exu_ready, lsu_ready});
      end
    end
    n_checks++;
    if ({rf_wen, retire_valid, misalign_err} !== 3'b000 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
      n_errors++; $display("FAIL reset_outputs: wen/ret/mis=%b waddr=%0d wdata=%h expected all 0",
                           {rf_wen, retire_valid, misalign_err}, rf_waddr, rf_wdata);
    end
    n_checks++;
    if (retire_cnt !== 32'd0) begin
      n_errors++; $display("FAIL reset_cnt: got %0d expected 0", retire_cnt);
    end
    exu_valid = 1'b0; lsu_valid = 1'b0; rst_n = 1'b1;
    exp_cnt = 32'd0;
    tick();
  endtask

  task automatic test_exu_only();
    exu_valid = 1'b1; exu_rd = 5'd5; exu_data = 32'hDEAD_BEEF;
    #1;
    n_checks++;
    if ({exu_ready, lsu_ready} !== 2'b10) begin
      n_errors++; $display("FAIL exu_only_ready: got %b expected 10", {exu_ready, lsu_ready});
    end
    tick();
    exu_valid = 1'b0;
    exp_cnt = exp_cnt + 1;
    n_checks++;
    if (rf_wen !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEAD_BEEF || retire_valid !== 1'b1
        || retire_cnt !== exp_cnt) begin
      n_errors++; $display("FAIL exu_only_write: wen=%b waddr=%0d wdata=%h ret=%b cnt=%0d expected 1/5/deadbeef/1/%0d",
                           rf_wen, rf_waddr, rf_wdata, retire_valid, retire_cnt, exp_cnt);
    end
    tick();
    n_checks++;
    if (rf_wen !== 1'b0 || retire_valid !== 1'b0 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEAD_BEEF) begin
      n_errors++; $display("FAIL exu_only_idle: wen=%b ret=%b waddr=%0d wdata=%h expected 0/0/5/deadbeef",
                           rf_wen, retire_valid, rf_waddr, rf_wdata);
    end
  endtask

  task automatic test_loads();
    logic [2:0]  f3 [5];
    logic [1:0]  lo [5];
    logic [31:0] ex [5];
    f3[0] = 3'b000; lo[0] = 2'd3; ex[0] = 32'hFFFF_FF80;
    f3[1] = 3'b100; lo[1] = 2'd3; ex[1] = 32'h0000_0080;
    f3[2] = 3'b001; lo[2] = 2'd2; ex[2] = 32'hFFFF_80FF;
    f3[3] = 3'b101; lo[3] = 2'd0; ex[3] = 32'h0000_7F01;
    f3[4] = 3'b010; lo[4] = 2'd0; ex[4] = 32'h80FF_7F01;
    lsu_rdata = 32'h80FF_7F01;
    for (int i = 0; i < 5; i++) begin
      lsu_valid = 1'b1; lsu_rd = 5'(10 + i); lsu_funct3 = f3[i]; lsu_addr_lo = lo[i];
      tick();
      exp_cnt = exp_cnt + 1;
      n_checks++;
      if (rf_wen !== 1'b1 || rf_waddr !== 5'(10 + i) || rf_wdata !== ex[i] || misalign_err !== 1'b0
          || retire_cnt !== exp_cnt) begin
        n_errors++; $display("FAIL load_%0d: wen=%b waddr=%0d wdata=%h mis=%b cnt=%0d expected 1/%0d/%h/0/%0d",
                             i, rf_wen, rf_waddr, rf_wdata, misalign_err, retire_cnt, 10 + i, ex[i], exp_cnt);
      end
    end
    lsu_valid = 1'b0;
    tick();
  endtask

  task automatic test_misaligned();
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_funct3 = 3'b010; lsu_addr_lo = 2'd1;
    #1;
    n_checks++;
    if (lsu_ready !== 1'b1) begin
      n_errors++; $display("FAIL misalign_ready: got %b expected 1", lsu_ready);
    end
    tick();
    exp_cnt = exp_cnt + 1;
    n_checks++;
    if (retire_valid !== 1'b1 || misalign_err !== 1'b1 || rf_wen !== 1'b0 || retire_cnt !== exp_cnt) begin
      n_errors++; $display("FAIL misalign_lw: ret=%b mis=%b wen=%b cnt=%0d expected 1/1/0/%0d",
                           retire_valid, misalign_err, rf_wen, retire_cnt, exp_cnt);
    end
    lsu_funct3 = 3'b011; lsu_addr_lo = 2'd0;
    tick();
    exp_cnt = exp_cnt + 1;
    n_checks++;
    if (retire_valid !== 1'b1 || misalign_err !== 1'b1 || rf_wen !== 1'b0 || retire_cnt !== exp_cnt) begin
      n_errors++; $display("FAIL bad_funct3: ret=%b mis=%b wen=%b cnt=%0d expected 1/1/0/%0d",
                           retire_valid, misalign_err, rf_wen, retire_cnt, exp_cnt);
    end
    lsu_valid = 1'b0;
    tick();
    n_checks++;
    if (misalign_err !== 1'b0 || retire_valid !== 1'b0) begin
      n_errors++; $display("FAIL misalign_clear: mis=%b ret=%b expected 0/0", misalign_err, retire_valid);
    end
  endtask

  task automatic test_arbitration();
    logic exp_exu;
    exu_valid = 1'b1; exu_rd = 5'd1; exu_data = 32'hAAAA_0001;
    lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_rdata = 32'h5555_0002; lsu_funct3 = 3'b010; lsu_addr_lo = 2'd0;
    for (int k = 0; k < 10; k++) begin
      exp_exu = ((k % 5) == 4);
      #1;
      n_checks++;
      if ({exu_ready, lsu_ready} !== {exp_exu, !exp_exu}) begin
        n_errors++; $display("FAIL arb_grant cyc%0d: exu/lsu ready=%b expected %b",
                             k, {exu_ready, lsu_ready}, {exp_exu, !exp_exu});
      end
      tick();
      exp_cnt = exp_cnt + 1;
      n_checks++;
      if (rf_waddr !== (exp_exu ? 5'd1 : 5'd2) || rf_wen !== 1'b1 || retire_cnt !== exp_cnt) begin
        n_errors++; $display("FAIL arb_write cyc%0d: waddr=%0d wen=%b cnt=%0d expected %0d/1/%0d",
                             k, rf_waddr, rf_wen, retire_cnt, exp_exu ? 1 : 2, exp_cnt);
      end
    end
    exu_valid = 1'b0; lsu_valid = 1'b0;
    tick();
  endtask

  task automatic test_rd_zero_and_reset();
    exu_valid = 1'b1; exu_rd = 5'd0; exu_data = 32'h0BAD_F00D;
    tick();
    exp_cnt = exp_cnt + 1;
    n_checks++;
    if (retire_valid !== 1'b1 || rf_wen !== 1'b0 || retire_cnt !== exp_cnt) begin
      n_errors++; $display("FAIL rd_zero: ret=%b wen=%b cnt=%0d expected 1/0/%0d",
                           retire_valid, rf_wen, retire_cnt, exp_cnt);
    end
    exu_rd = 5'd3; exu_data = 32'h0000_0033;
    tick();
    n_checks++;
    if (rf_wen !== 1'b1 || rf_waddr !== 5'd3) begin
      n_errors++; $display("FAIL pre_reset_write: wen=%b waddr=%0d expected 1/3", rf_wen, rf_waddr);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (exu_ready !== 1'b0) begin
      n_errors++; $display("FAIL reset_ready_mid: got %b expected 0", exu_ready);
    end
    tick();
    n_checks++;
    if (rf_wen !== 1'b0 || retire_valid !== 1'b0 || retire_cnt !== 32'd0) begin
      n_errors++; $display("FAIL mid_reset: wen=%b ret=%b cnt=%0d expected 0/0/0",
                           rf_wen, retire_valid, retire_cnt);
    end
    exu_valid = 1'b0; rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; exu_valid = 1'b0; lsu_valid = 1'b0;
    exu_rd = '0; exu_data = '0; lsu_rd = '0; lsu_rdata = '0;
    lsu_funct3 = '0; lsu_addr_lo = '0; exp_cnt = '0;
    #2;
    test_reset();
    test_exu_only();
    test_loads();
    test_misaligned();
    test_arbitration();
    test_rd_zero_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
